// File: rtl/i_decode.sv
// Instruction-decode stage: register file with write-first bypass, MIPS-subset
// control decode, sign extension, load-use stall detection and the ID/EX register.
module i_decode #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] IF_ID_instr,
  input  logic [DW-1:0] IF_ID_npc,
  input  logic          EX_MEM_PCSrc,
  input  logic          MEM_WB_RegWrite,
  input  logic [4:0]    MEM_WB_rd,
  input  logic [DW-1:0] MEM_WB_wdata,
  output logic [1:0]    ID_EX_wb,
  output logic [2:0]    ID_EX_m,
  output logic [3:0]    ID_EX_ex,
  output logic [DW-1:0] ID_EX_npc,
  output logic [DW-1:0] ID_EX_rdata1,
  output logic [DW-1:0] ID_EX_rdata2,
  output logic [DW-1:0] ID_EX_sext,
  output logic [4:0]    ID_EX_rt,
  output logic [4:0]    ID_EX_rd,
  output logic [4:0]    ID_EX_rs,
  output logic          pc_write,
  output logic          if_id_write
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [DW-1:0] r_regs [NREG];

  logic [5:0]    w_opcode;
  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [4:0]    w_rd;
  logic [DW-1:0] w_sext;
  logic [DW-1:0] w_rdata1;
  logic [DW-1:0] w_rdata2;
  logic          w_we;
  logic          w_stall;
  logic          w_bubble;
  logic [1:0]    w_wb;
  logic [2:0]    w_m;
  logic [3:0]    w_ex;

  assign w_opcode = IF_ID_instr[31:26];
  assign w_rs     = IF_ID_instr[25:21];
  assign w_rt     = IF_ID_instr[20:16];
  assign w_rd     = IF_ID_instr[15:11];
  assign w_sext   = {{(DW-16){IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  // A write to r0 is never a real write, so it must neither update nor bypass.
  assign w_we = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0);

  assign w_rdata1 = (w_rs == 5'd0)                ? {DW{1'b0}}   :
                    (w_we && (MEM_WB_rd == w_rs)) ? MEM_WB_wdata :
                                                    r_regs[w_rs];
  assign w_rdata2 = (w_rt == 5'd0)                ? {DW{1'b0}}   :
                    (w_we && (MEM_WB_rd == w_rt)) ? MEM_WB_wdata :
                                                    r_regs[w_rt];

  // Load in EX whose destination feeds the instruction now in ID.
  assign w_stall  = ID_EX_m[1] && ((ID_EX_rt == w_rs) || (ID_EX_rt == w_rt));
  assign w_bubble = EX_MEM_PCSrc || w_stall;

  // Fetch is never held during reset or a redirect; flush outranks stall.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (rst || EX_MEM_PCSrc) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end else if (w_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  always_comb begin
    w_wb = 2'b00;
    w_m  = 3'b000;
    w_ex = 4'b0000;
    case (w_opcode)
      OP_RTYPE: begin
        w_wb = 2'b10;
        w_m  = 3'b000;
        w_ex = 4'b1100;
      end
      OP_LW: begin
        w_wb = 2'b11;
        w_m  = 3'b010;
        w_ex = 4'b0001;
      end
      OP_SW: begin
        w_wb = 2'b00;
        w_m  = 3'b001;
        w_ex = 4'b0001;
      end
      OP_BEQ: begin
        w_wb = 2'b00;
        w_m  = 3'b100;
        w_ex = 4'b0010;
      end
      default: begin
        w_wb = 2'b00;
        w_m  = 3'b000;
        w_ex = 4'b0000;
      end
    endcase
  end

  // Register file; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {DW{1'b0}};
      end
    end else if (w_we) begin
      r_regs[MEM_WB_rd] <= MEM_WB_wdata;
    end else begin
      r_regs[0] <= {DW{1'b0}};
    end
  end

  // ID/EX pipeline register; controls collapse to a bubble on flush or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_wb     <= 2'b00;
      ID_EX_m      <= 3'b000;
      ID_EX_ex     <= 4'b0000;
      ID_EX_npc    <= {DW{1'b0}};
      ID_EX_rdata1 <= {DW{1'b0}};
      ID_EX_rdata2 <= {DW{1'b0}};
      ID_EX_sext   <= {DW{1'b0}};
      ID_EX_rt     <= 5'd0;
      ID_EX_rd     <= 5'd0;
      ID_EX_rs     <= 5'd0;
    end else begin
      if (w_bubble) begin
        ID_EX_wb <= 2'b00;
        ID_EX_m  <= 3'b000;
        ID_EX_ex <= 4'b0000;
      end else begin
        ID_EX_wb <= w_wb;
        ID_EX_m  <= w_m;
        ID_EX_ex <= w_ex;
      end
      ID_EX_npc    <= IF_ID_npc;
      ID_EX_rdata1 <= w_rdata1;
      ID_EX_rdata2 <= w_rdata2;
      ID_EX_sext   <= w_sext;
      ID_EX_rt     <= w_rt;
      ID_EX_rd     <= w_rd;
      ID_EX_rs     <= w_rs;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Directed, table-driven bench for the i_decode stage plus hand-written
// reset and stall/flush sequences.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        EX_MEM_PCSrc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_wdata;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_m;
  logic [3:0]  ID_EX_ex;
  logic [31:0] ID_EX_npc;
  logic [31:0] ID_EX_rdata1;
  logic [31:0] ID_EX_rdata2;
  logic [31:0] ID_EX_sext;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  ID_EX_rs;
  logic        pc_write;
  logic        if_id_write;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i_decode dut (
    .clk(clk), .rst(rst),
    .IF_ID_instr(IF_ID_instr), .IF_ID_npc(IF_ID_npc),
    .EX_MEM_PCSrc(EX_MEM_PCSrc),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_wdata(MEM_WB_wdata),
    .ID_EX_wb(ID_EX_wb), .ID_EX_m(ID_EX_m), .ID_EX_ex(ID_EX_ex),
    .ID_EX_npc(ID_EX_npc), .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2),
    .ID_EX_sext(ID_EX_sext), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd), .ID_EX_rs(ID_EX_rs),
    .pc_write(pc_write), .if_id_write(if_id_write)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        pcsrc;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        pcw;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic        chk_data;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
    input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
    input logic pcw, input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
    input logic chk_data, input logic [31:0] r1, input logic [31:0] r2,
    input logic [31:0] sext, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    vec_t v;
    v.instr = instr; v.npc = npc; v.pcsrc = pcsrc;
    v.we = we; v.wrd = wrd; v.wdata = wdata;
    v.pcw = pcw; v.wb = wb; v.m = m; v.ex = ex;
    v.chk_data = chk_data; v.r1 = r1; v.r2 = r2; v.sext = sext;
    v.rs = rs; v.rt = rt; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wdata);
    IF_ID_instr     = instr;
    IF_ID_npc       = npc;
    EX_MEM_PCSrc    = pcsrc;
    MEM_WB_RegWrite = we;
    MEM_WB_rd       = wrd;
    MEM_WB_wdata    = wdata;
  endtask

  task automatic chk_ctrl(input string tag, input logic [1:0] wb, input logic [2:0] m,
                          input logic [3:0] ex);
    chk({tag, ".wb"}, {30'd0, ID_EX_wb}, {30'd0, wb});
    chk({tag, ".m"},  {29'd0, ID_EX_m},  {29'd0, m});
    chk({tag, ".ex"}, {28'd0, ID_EX_ex}, {28'd0, ex});
  endtask

  initial begin
    vecs[0]  = mk(32'h00A02020, 32'h04, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b10, 3'b000, 4'b1100, 1'b1, 32'h0, 32'h0,        32'h00002020, 5'd5, 5'd0, 5'd4);
    vecs[1]  = mk(32'hFC000000, 32'h00, 1'b0, 1'b1, 5'd1, 32'h0000000A, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b1, 32'h0, 32'h0,        32'h00000000, 5'd0, 5'd0, 5'd0);
    vecs[2]  = mk(32'hFC221234, 32'h04, 1'b0, 1'b1, 5'd2, 32'h00000005, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b1, 32'hA, 32'h5,        32'h00001234, 5'd1, 5'd2, 5'd2);
    vecs[3]  = mk(32'h00221820, 32'h08, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b10, 3'b000, 4'b1100, 1'b1, 32'hA, 32'h5,        32'h00001820, 5'd1, 5'd2, 5'd3);
    vecs[4]  = mk(32'hAC04FFFC, 32'h0C, 1'b0, 1'b1, 5'd4, 32'hDEADBEEF, 1'b1, 2'b00, 3'b001, 4'b0001, 1'b1, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd0, 5'd4, 5'd31);
    vecs[5]  = mk(32'h00002820, 32'h10, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 2'b10, 3'b000, 4'b1100, 1'b1, 32'h0, 32'h0,        32'h00002820, 5'd0, 5'd0, 5'd5);
    vecs[6]  = mk(32'h00003020, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b10, 3'b000, 4'b1100, 1'b1, 32'h0, 32'h0,        32'h00003020, 5'd0, 5'd0, 5'd6);
    vecs[7]  = mk(32'h10220003, 32'h18, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b00, 3'b100, 4'b0010, 1'b1, 32'hA, 32'h5,        32'h00000003, 5'd1, 5'd2, 5'd0);
    vecs[8]  = mk(32'h8C220000, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b11, 3'b010, 4'b0001, 1'b1, 32'hA, 32'h5,        32'h00000000, 5'd1, 5'd2, 5'd0);
    vecs[9]  = mk(32'h00452020, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 3'b000, 4'b0000, 1'b0, 32'h0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd0);
    vecs[10] = mk(32'h00452020, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b10, 3'b000, 4'b1100, 1'b1, 32'h5, 32'h0,        32'h00002020, 5'd2, 5'd5, 5'd4);
    vecs[11] = mk(32'h10220003, 32'h24, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 2'b00, 3'b000, 4'b0000, 1'b1, 32'hA, 32'h5,        32'h00000003, 5'd1, 5'd2, 5'd0);
    vecs[12] = mk(32'h8C220000, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b11, 3'b010, 4'b0001, 1'b1, 32'hA, 32'h5,        32'h00000000, 5'd1, 5'd2, 5'd0);
    vecs[13] = mk(32'h00452020, 32'h2C, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 2'b00, 3'b000, 4'b0000, 1'b0, 32'h0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd0);
    vecs[14] = mk(32'h00452020, 32'h2C, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 2'b10, 3'b000, 4'b1100, 1'b1, 32'h5, 32'h0,        32'h00002020, 5'd2, 5'd5, 5'd4);

    // Reset held two cycles with a pending write that must be dropped.
    rst = 1'b1;
    drive(32'h8C220000, 32'h0, 1'b0, 1'b1, 5'd5, 32'hCAFEF00D);
    repeat (2) @(posedge clk);
    #1;
    chk_ctrl("reset", 2'b00, 3'b000, 4'b0000);
    chk("reset.npc",    ID_EX_npc,    32'h0);
    chk("reset.rdata1", ID_EX_rdata1, 32'h0);
    chk("reset.sext",   ID_EX_sext,   32'h0);
    chk("reset.rt",     {27'd0, ID_EX_rt}, 32'h0);
    chk("reset.pc_write", {31'd0, pc_write}, 32'h1);
    chk("reset.if_id_write", {31'd0, if_id_write}, 32'h1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].npc, vecs[i].pcsrc, vecs[i].we, vecs[i].wrd, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d.pc_write", i),    {31'd0, pc_write},    {31'd0, vecs[i].pcw});
      chk($sformatf("v%0d.if_id_write", i), {31'd0, if_id_write}, {31'd0, vecs[i].pcw});
      @(posedge clk);
      #1;
      chk_ctrl($sformatf("v%0d", i), vecs[i].wb, vecs[i].m, vecs[i].ex);
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d.npc", i),    ID_EX_npc,    vecs[i].npc);
        chk($sformatf("v%0d.rdata1", i), ID_EX_rdata1, vecs[i].r1);
        chk($sformatf("v%0d.rdata2", i), ID_EX_rdata2, vecs[i].r2);
        chk($sformatf("v%0d.sext", i),   ID_EX_sext,   vecs[i].sext);
        chk($sformatf("v%0d.rs", i), {27'd0, ID_EX_rs}, {27'd0, vecs[i].rs});
        chk($sformatf("v%0d.rt", i), {27'd0, ID_EX_rt}, {27'd0, vecs[i].rt});
        chk($sformatf("v%0d.rd", i), {27'd0, ID_EX_rd}, {27'd0, vecs[i].rd});
      end
    end

    // Reset mid-operation: a live load-use hazard and a write are both overridden.
    drive(32'h8C220000, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk_ctrl("pre_rst_lw", 2'b11, 3'b010, 4'b0001);
    drive(32'h00452020, 32'h34, 1'b0, 1'b1, 5'd7, 32'h00000077);
    #1;
    chk("pre_rst.stall_pc_write", {31'd0, pc_write}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst.pc_write", {31'd0, pc_write}, 32'h1);
    @(posedge clk);
    #1;
    chk_ctrl("mid_rst", 2'b00, 3'b000, 4'b0000);
    chk("mid_rst.npc", ID_EX_npc, 32'h0);
    rst = 1'b0;
    drive(32'h00270020, 32'h38, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst.r1_cleared", ID_EX_rdata1, 32'h0);
    chk("post_rst.r7_dropped", ID_EX_rdata2, 32'h0);
    chk("post_rst.npc", ID_EX_npc, 32'h38);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
